// File: rtl/dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_pkg : shared types and window constants for the DMA blocks        |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
package dma_pkg;

  localparam int DMA_OFS_W = 23;
  localparam int DMA_TAG_W = 9;

  localparam logic [DMA_TAG_W-1:0] DMA_WIN_TAG = 9'hF0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_ROOM = 2'd2,
    ST_FLUSH     = 2'd3
  } dma_state_e;

  function automatic logic [31:0] dma_win_addr(input logic [DMA_TAG_W-1:0] tag,
                                               input logic [DMA_OFS_W-1:0] ofs);
    return {tag, ofs};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, power-of-two depth, head reads 0 when  |
// |             empty                                                     |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full_cnt = (c_aw+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_full_cnt);
  assign o_count   = r_count;
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_burst_reader : Wishbone read initiator streaming a word block     |
// |                    from the SDRAM window into a valid/ready FIFO      |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
module dma_burst_reader
  import dma_pkg::*;
#(
  parameter logic [8:0] WIN_TAG    = DMA_WIN_TAG,
  parameter int         FIFO_DEPTH = 8,
  parameter int         LEN_W      = 16,
  parameter int         TIMEOUT    = 255
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [22:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             dma_wbs_cyc_o,
  output logic             dma_wbs_stb_o,
  output logic             dma_wbs_we_o,
  output logic [31:0]      dma_wbs_adr_o,
  input  logic [31:0]      dma_dat_i,
  input  logic             dma_ack_i,
  input  logic             dma_brust_valid_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] burst_hits
);

  localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
  localparam int c_to_w  = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_to_w-1:0]  c_to_last = c_to_w'(TIMEOUT - 1);

  dma_state_e          r_state;
  logic                r_cyc;
  logic                r_stb;
  logic [31:0]         r_adr;
  logic [LEN_W-1:0]    r_remain;
  logic [c_to_w-1:0]   r_to;
  logic                r_done;
  logic                r_err;
  logic [LEN_W-1:0]    r_hits;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [c_cnt_w-1:0]  w_count;
  logic [c_cnt_w-1:0]  w_cnt_next;
  logic                w_room_after;
  logic                w_unused;

  assign w_unused      = &{1'b0, cmd_addr[1:0]};

  assign cmd_ready     = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign dma_wbs_cyc_o = r_cyc;
  assign dma_wbs_stb_o = r_stb;
  assign dma_wbs_we_o  = 1'b0;
  assign dma_wbs_adr_o = r_adr;
  assign done          = r_done;
  assign err           = r_err;
  assign burst_hits    = r_hits;

  assign out_valid     = !w_empty;
  assign w_pop         = out_valid && out_ready;
  assign w_push        = (r_state == ST_REQ) && r_stb && dma_ack_i;

  // A new strobe needs a free slot after this edge's push and pop settle.
  assign w_cnt_next    = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
  assign w_room_after  = (w_cnt_next < c_depth);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (dma_dat_i),
    .i_pop   (w_pop),
    .o_rdata (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_adr    <= '0;
      r_remain <= '0;
      r_to     <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_hits   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_adr    <= dma_win_addr(WIN_TAG, {cmd_addr[22:2], 2'b00});
            r_remain <= cmd_len;
            r_err    <= 1'b0;
            r_hits   <= '0;
            r_to     <= '0;
            if (cmd_len == '0)  r_state <= ST_FLUSH;
            else if (!w_full)   r_state <= ST_REQ;
            else                r_state <= ST_WAIT_ROOM;
          end
        end

        ST_REQ: begin
          if (!r_stb) begin
            // First strobe of a command, slot reserved at the handshake.
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
          end else if (dma_ack_i) begin
            r_to     <= '0;
            r_adr    <= dma_win_addr(WIN_TAG, r_adr[22:0] + 23'd4);
            r_remain <= r_remain - LEN_W'(1);
            if (dma_brust_valid_i) r_hits <= r_hits + LEN_W'(1);
            if (r_remain == LEN_W'(1)) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_state <= ST_FLUSH;
            end else if (!w_room_after) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_state <= ST_WAIT_ROOM;
            end
          end else if (r_to == c_to_last) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_FLUSH;
          end else begin
            r_to <= r_to + c_to_w'(1);
          end
        end

        ST_WAIT_ROOM: begin
          if (!w_full) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= ST_REQ;
          end
        end

        ST_FLUSH: begin
          // One idle cycle after the bus drops, then the done pulse.
          if (!r_done) begin
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dma_burst_reader : self-checking bench with Wishbone responder,    |
// |                       stream consumer and reference model             |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
module tb_dma_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [22:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [31:0] dat = '0;
  logic        ack = 1'b0;
  logic        bv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy, done, err;
  logic [15:0] burst_hits;

  int total = 0;
  int bad = 0;

  dma_burst_reader dut (
    .wb_clk_i          (clk),
    .rst_n             (rst_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .dma_wbs_cyc_o     (cyc),
    .dma_wbs_stb_o     (stb),
    .dma_wbs_we_o      (we),
    .dma_wbs_adr_o     (adr),
    .dma_dat_i         (dat),
    .dma_ack_i         (ack),
    .dma_brust_valid_i (bv),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .burst_hits        (burst_hits)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  initial forever begin @(posedge clk); cyc_n++; end

  // Responder configuration and logs
  bit          resp_on = 1'b1, resp_rand = 1'b0, resp_bv = 1'b0, resp_bv_rand = 1'b0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_dat = '0;
  int          resp_lat = 0, cur_lat = 0, wcnt = 0, bv_cnt = 0;
  logic [31:0] adr_log[$];
  int          ack_cyc[$];
  logic [31:0] rx[$];
  int          rdy_mode = 1;
  int          done_cnt = 0, done_cyc = -1, rises = 0, rise_cyc = -1;
  int          fall_cyc = -1, err_cyc = -1, stb_hi = 0, hs_cyc = 0;
  bit          p_stb = 1'b0, p_err = 1'b0;

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234 ^ (a << 5);
  endfunction

  function automatic logic [31:0] exp_adr(input logic [22:0] base, input int i);
    logic [22:0] ofs;
    ofs = {base[22:2], 2'b00} + 23'(i * 4);
    return 32'h7800_0000 | {9'd0, ofs};
  endfunction

  initial forever begin
    @(negedge clk);
    if (resp_on && stb) begin
      if (wcnt >= cur_lat) begin
        ack = 1'b1;
        dat = use_fixed ? fixed_dat : dfun(adr);
        bv  = resp_bv_rand ? 1'($urandom_range(0, 1)) : resp_bv;
        adr_log.push_back(adr);
        ack_cyc.push_back(cyc_n + 1);
        if (bv) bv_cnt++;
        wcnt = 0;
        cur_lat = resp_rand ? int'($urandom_range(0, 3)) : resp_lat;
      end else begin
        ack = 1'b0;
        wcnt++;
      end
    end else begin
      ack = 1'b0; bv = 1'b0; wcnt = 0;
      cur_lat = resp_rand ? int'($urandom_range(0, 3)) : resp_lat;
    end
  end

  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (rst_n && out_valid && out_ready) rx.push_back(out_data);
  end

  initial forever begin
    @(negedge clk);
    if (stb) stb_hi++;
    if (stb && !p_stb) begin rises++; rise_cyc = cyc_n; end
    if (!stb && p_stb) fall_cyc = cyc_n;
    if (err && !p_err) err_cyc = cyc_n;
    if (done) begin done_cnt++; done_cyc = cyc_n; end
    p_stb = stb;
    p_err = err;
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_logs;
    adr_log.delete(); ack_cyc.delete(); rx.delete();
    bv_cnt = 0; done_cnt = 0; rises = 0; stb_hi = 0;
  endtask

  task automatic send_cmd(input logic [22:0] a, input logic [15:0] l, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      tick(1);
    end
    cmd_addr = a; cmd_len = l; cmd_valid = ok;
    tick(1);
    hs_cyc = cyc_n;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = done_cnt;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick(1);
      if (done_cnt > start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drain(input int n, input int budget);
    rdy_mode = 1;
    for (int k = 0; k < budget; k++) begin
      if (rx.size() >= n) break;
      tick(1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    total++; if ({cmd_ready, cyc, stb, we, out_valid, busy, done, err} !== 8'b1000_0000) begin
      bad++; $display("FAIL reset_flags got=%b want=10000000", {cmd_ready, cyc, stb, we, out_valid, busy, done, err}); end
    total++; if (adr !== 32'h0) begin bad++; $display("FAIL reset_adr got=%h want=0", adr); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (burst_hits !== 16'h0) begin bad++; $display("FAIL reset_hits got=%0d want=0", burst_hits); end
    rst_n = 1'b1;
    tick(2);
    total++; if ({cmd_ready, busy} !== 2'b10) begin bad++; $display("FAIL reset_idle got=%b want=10", {cmd_ready, busy}); end
  endtask

  task automatic test_single;
    bit ok;
    logic [31:0] v;
    clear_logs();
    resp_on = 1; resp_rand = 0; resp_lat = 3; resp_bv = 0; resp_bv_rand = 0;
    use_fixed = 1; fixed_dat = 32'hDEAD_BEEF; rdy_mode = 1;
    send_cmd(23'h000010, 16'd1, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_cmd_accept got=0 want=1"); end
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done_seen got=0 want=1"); end
    tick(4);
    total++; if (rise_cyc !== hs_cyc + 1) begin bad++; $display("FAIL single_first_stb got=%0d want=%0d", rise_cyc, hs_cyc + 1); end
    v = (adr_log.size() > 0) ? adr_log[0] : 32'hxxxx_xxxx;
    total++; if (adr_log.size() !== 1 || v !== 32'h7800_0010) begin bad++; $display("FAIL single_adr got=%h n=%0d want=78000010", v, adr_log.size()); end
    v = (rx.size() > 0) ? rx[0] : 32'hxxxx_xxxx;
    total++; if (rx.size() !== 1 || v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_data got=%h n=%0d want=deadbeef", v, rx.size()); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_cnt); end
    total++; if (ack_cyc.size() > 0 && done_cyc !== ack_cyc[$] + 1) begin bad++; $display("FAIL single_done_latency got=%0d want=%0d", done_cyc, ack_cyc[$] + 1); end
    total++; if ({err, busy} !== 2'b00) begin bad++; $display("FAIL single_err_busy got=%b want=00", {err, busy}); end
    use_fixed = 0;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int miss_a, miss_d, miss_c;
    clear_logs();
    resp_lat = 0; resp_rand = 0; resp_bv = 1; rdy_mode = 1;
    send_cmd(23'h0, 16'd8, ok);
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_done_seen got=0 want=1"); end
    drain(8, 20);
    miss_a = 0; miss_d = 0; miss_c = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= adr_log.size() || adr_log[i] !== exp_adr(23'h0, i)) miss_a++;
      if (i >= rx.size() || rx[i] !== dfun(exp_adr(23'h0, i))) miss_d++;
      if (i >= ack_cyc.size() || ack_cyc[i] !== ack_cyc[0] + i) miss_c++;
    end
    total++; if (miss_a !== 0 || adr_log.size() !== 8) begin bad++; $display("FAIL b2b_addr got=%0d_bad n=%0d want=0_bad n=8", miss_a, adr_log.size()); end
    total++; if (miss_c !== 0) begin bad++; $display("FAIL b2b_consecutive got=%0d_gaps want=0", miss_c); end
    total++; if (miss_d !== 0 || rx.size() !== 8) begin bad++; $display("FAIL b2b_data got=%0d_bad n=%0d want=0_bad n=8", miss_d, rx.size()); end
    total++; if (burst_hits !== 16'd8) begin bad++; $display("FAIL b2b_hits got=%0d want=8", burst_hits); end
    resp_bv = 0;
  endtask

  task automatic test_backpressure;
    bit ok;
    int miss;
    clear_logs();
    resp_lat = 0; rdy_mode = 0;
    send_cmd(23'h000200, 16'd12, ok);
    tick(40);
    total++; if (adr_log.size() !== 8) begin bad++; $display("FAIL bp_acks_stalled got=%0d want=8", adr_log.size()); end
    total++; if ({stb, busy} !== 2'b01) begin bad++; $display("FAIL bp_wait_room got=%b want=01", {stb, busy}); end
    rdy_mode = 1;
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_done_seen got=0 want=1"); end
    drain(12, 40);
    miss = 0;
    for (int i = 0; i < 12; i++)
      if (i >= rx.size() || rx[i] !== dfun(exp_adr(23'h000200, i))) miss++;
    total++; if (miss !== 0 || rx.size() !== 12) begin bad++; $display("FAIL bp_data got=%0d_bad n=%0d want=0_bad n=12", miss, rx.size()); end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [31:0] want [3];
    logic [31:0] v;
    want[0] = 32'h787F_FFF8; want[1] = 32'h787F_FFFC; want[2] = 32'h7800_0000;
    clear_logs();
    resp_lat = 1; rdy_mode = 1;
    send_cmd(23'h7FFFF8, 16'd3, ok);
    wait_done(60, ok);
    drain(3, 20);
    for (int i = 0; i < 3; i++) begin
      v = (i < adr_log.size()) ? adr_log[i] : 32'hxxxx_xxxx;
      total++; if (v !== want[i]) begin bad++; $display("FAIL wrap_adr%0d got=%h want=%h", i, v, want[i]); end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int hi;
    clear_logs();
    resp_on = 0; rdy_mode = 1;
    send_cmd(23'h000040, 16'd4, ok);
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_done_seen got=0 want=1"); end
    tick(2);
    hi = stb_hi;
    total++; if (hi !== 255) begin bad++; $display("FAIL to_stb_cycles got=%0d want=255", hi); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err); end
    total++; if (fall_cyc !== err_cyc) begin bad++; $display("FAIL to_err_timing got=%0d want=%0d", err_cyc, fall_cyc); end
    total++; if (rx.size() !== 0 || done_cnt !== 1) begin bad++; $display("FAIL to_side_effects got=rx%0d/done%0d want=rx0/done1", rx.size(), done_cnt); end
    resp_on = 1; resp_lat = 0;
    send_cmd(23'h000080, 16'd1, ok);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL to_err_clear got=%b want=0", err); end
    wait_done(40, ok);
    drain(1, 20);
    total++; if (rx.size() !== 1) begin bad++; $display("FAIL to_recover got=%0d want=1", rx.size()); end
  endtask

  task automatic test_reset_mid_and_zero;
    bit ok;
    clear_logs();
    resp_lat = 0; rdy_mode = 0;
    send_cmd(23'h0, 16'd12, ok);
    tick(4);
    total++; if ({cyc, stb} !== 2'b11) begin bad++; $display("FAIL rst_pre_active got=%b want=11", {cyc, stb}); end
    rst_n = 1'b0;
    #1;
    total++; if ({cyc, stb} !== 2'b00) begin bad++; $display("FAIL rst_async_drop got=%b want=00", {cyc, stb}); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    total++; if ({out_valid, busy, cmd_ready} !== 3'b001) begin bad++; $display("FAIL rst_fifo_empty got=%b want=001", {out_valid, busy, cmd_ready}); end
    clear_logs();
    rdy_mode = 1;
    send_cmd(23'h000100, 16'd0, ok);
    wait_done(20, ok);
    tick(3);
    total++; if (done_cnt !== 1 || done_cyc !== hs_cyc + 1) begin bad++; $display("FAIL zero_done got=n%0d@%0d want=n1@%0d", done_cnt, done_cyc, hs_cyc + 1); end
    total++; if (rises !== 0 || adr_log.size() !== 0) begin bad++; $display("FAIL zero_no_bus got=%0d_strobes want=0", rises); end
  endtask

  task automatic test_random;
    bit ok;
    logic [22:0] base;
    int len, miss_a, miss_d;
    resp_rand = 1; resp_bv_rand = 1;
    for (int t = 0; t < 6; t++) begin
      clear_logs();
      base = 23'($urandom);
      len  = $urandom_range(1, 20);
      rdy_mode = 2;
      send_cmd(base, 16'(len), ok);
      wait_done(600, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand%0d_done_seen got=0 want=1", t); end
      drain(len, 60);
      miss_a = 0; miss_d = 0;
      for (int i = 0; i < len; i++) begin
        if (i >= adr_log.size() || adr_log[i] !== exp_adr(base, i)) miss_a++;
        if (i >= rx.size() || rx[i] !== dfun(exp_adr(base, i))) miss_d++;
      end
      total++; if (miss_a !== 0 || adr_log.size() !== len) begin bad++; $display("FAIL rand%0d_addr got=%0d_bad n=%0d want=0_bad n=%0d", t, miss_a, adr_log.size(), len); end
      total++; if (miss_d !== 0 || rx.size() !== len) begin bad++; $display("FAIL rand%0d_data got=%0d_bad n=%0d want=0_bad n=%0d", t, miss_d, rx.size(), len); end
      total++; if (burst_hits !== 16'(bv_cnt)) begin bad++; $display("FAIL rand%0d_hits got=%0d want=%0d", t, burst_hits, bv_cnt); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rand%0d_err got=%b want=0", t, err); end
    end
    resp_rand = 0; resp_bv_rand = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_timeout();
    test_reset_mid_and_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_burst_reader.md
# dma_burst_reader

Wishbone-initiator DMA engine that drives the user project's `dma_wbs_*` port to stream a contiguous block of words out of the SDRAM window. Used by the management SoC side, it is the other end of the DMA interface the SDRAM user project exposes. A command gives a word address and length. The block issues one read per word in the `9'hF0` window and pushes returned data into an internal FIFO, which drains through a valid/ready stream. A timeout aborts stalled transfers.

## Interface
- `WIN_TAG`, `9'hF0`: value driven on `dma_wbs_adr_o[31:23]`; selects the SDRAM window.
- `FIFO_DEPTH`, `8`: output FIFO entries; power of two, ≥2.
- `LEN_W`, `16`: width of the command word count.
- `TIMEOUT`, `255`: maximum cycles a request may wait for ack before abort.
- `wb_clk_i` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: high only in IDLE.
- `cmd_addr` input 23: start byte address within the window; bits [1:0] ignored and forced to 0.
- `cmd_len` input LEN_W: number of 32-bit words to read.
- `dma_wbs_cyc_o` output 1: Wishbone cycle.
- `dma_wbs_stb_o` output 1: Wishbone strobe.
- `dma_wbs_we_o` output 1: always 0.
- `dma_wbs_adr_o` output 32: `{WIN_TAG, word_addr}`.
- `dma_dat_i` input 32: read data, valid with `dma_ack_i`.
- `dma_ack_i` input 1: responder acknowledge.
- `dma_brust_valid_i` input 1: responder burst/prefetch data is streaming; counted in `burst_hits`.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts.
- `out_data` output 32: FIFO head.
- `busy` output 1: not IDLE.
- `done` output 1: one-cycle pulse at transfer end.
- `err` output 1: sticky timeout flag; cleared by the next accepted command.
- `burst_hits` output LEN_W: acks that arrived with `dma_brust_valid_i` high in the current or last transfer.

## Operation
- States: IDLE, REQ, WAIT_ROOM, FLUSH.
- **IDLE**
  - A handshake (`cmd_valid && cmd_ready`) latches addr and len, clears `err` and `burst_hits`, and resets the timeout counter.
  - `cmd_len==0` goes directly to FLUSH, with `done` next cycle and no bus activity.
  - Otherwise go to REQ if the FIFO has a free slot, else to WAIT_ROOM.
- **REQ**
  - `cyc=stb=1`, `we=0`, with a stable address.
  - On `dma_ack_i`:
    - push `dma_dat_i`;
    - decrement remaining;
    - advance `word_addr` by 4, wrapping mod 2^23;
    - increment `burst_hits` if `dma_brust_valid_i`.
  - If remaining becomes 0, go to FLUSH with `cyc/stb` low next cycle.
  - Else, if the FIFO still has a free slot after this cycle's push and pop, stay in REQ with `stb` held high (back-to-back reads). Otherwise go to WAIT_ROOM.
- **WAIT_ROOM**
  - `cyc=stb=0`.
  - Return to REQ when free slots ≥1.
- **Flow control:** a strobe is never raised without a reserved FIFO slot. `stb` never drops before ack, except on timeout.
- **Timeout:** in REQ, the counter increments each cycle without ack and resets on ack. When it reaches `TIMEOUT`:
  - drop `cyc/stb`;
  - set `err`;
  - go to FLUSH.
  - Already-pushed data remains in the FIFO and drains normally.
- **FLUSH:** pulse `done` for one cycle, then go to IDLE. `done` does not wait for the FIFO to drain.
- **FIFO:** simultaneous push and pop when full or empty are both legal. Push when full is impossible by construction.
- **Reset mid-transfer:** all state clears immediately. `cyc/stb` fall asynchronously and FIFO contents are discarded.

## Timing
- **Reset values:**
  - `cmd_ready=1`;
  - `dma_wbs_cyc_o=dma_wbs_stb_o=dma_wbs_we_o=0`;
  - `dma_wbs_adr_o=0`;
  - `out_valid=0`;
  - `out_data=0`;
  - `busy=0`, `done=0`, `err=0`;
  - `burst_hits=0`.
- All outputs are registered except `cmd_ready`, `busy` (state decode) and `out_valid`/`out_data` (FIFO head).
- **Command to first strobe:** 1 cycle (handshake at edge N, `stb` high after edge N+1).
- **Ack handling:** ack sampled at an edge moves the data to `out_data` and asserts `out_valid` on the following cycle. The next address is presented in the same cycle.
- **Peak throughput:** one word per cycle when the responder acks every cycle and `out_ready=1`.
- **Last ack to `done`:** last ack at edge N, `done` high for cycle N+1 to N+2. `busy` falls with the end of `done`.
- **Timeout:** `stb` falls `TIMEOUT` cycles after it rose without ack, and `err` is set in the same cycle.

## Structure
- Shared package `dma_pkg`:
  - state enum (IDLE/REQ/WAIT_ROOM/FLUSH);
  - default `WIN_TAG` constant `9'hF0`;
  - window-address helper width constants (23-bit offset, 9-bit tag).
- One sub-module, `sync_fifo`: parameterised width/depth; `push`/`pop`/`full`/`empty`/`count`; asynchronous active-low reset. It is reusable by other DMA blocks.

## Test plan
- **Single word:** `cmd_addr=23'h000010`, `len=1`; responder acks after 3 cycles with `32'hDEADBEEF` → `adr_o=32'h78000010`, `out_data=32'hDEADBEEF`, one `done` pulse, `err=0`.
- **Back-to-back:** `len=8`, responder acks every cycle with `dma_brust_valid_i=1`, `out_ready=1` → addresses `0x78000000`..`0x7800001C` on consecutive cycles, `burst_hits=8`, 8 words in order.
- **Backpressure:** `len=12`, `out_ready=0` → exactly 8 acks, then `stb` low in WAIT_ROOM. Raising `out_ready` resumes the transfer, and all 12 words arrive in order.
- **Wrap:** `cmd_addr=23'h7FFFF8`, `len=3` → offsets `7FFFF8`, `7FFFFC`, `000000`.
- **Timeout:** `TIMEOUT=255`, responder never acks → `stb` falls after 255 cycles, `err=1`, `done` pulses. The next command clears `err`.
- **Reset mid-transfer and zero length:** asserting `rst_n=0` during REQ drops `cyc` immediately, and the FIFO is empty after release. A `len=0` command produces `done` with no strobe.
